// File: rtl/conv_pkg.sv
// Shared definitions for the layer-2 convolution sequencer: state encoding,
// default map geometry and a width helper that never returns zero.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_e;

    localparam int IMG_W_DEF    = 26;
    localparam int IMG_H_DEF    = 26;
    localparam int PIPE_LAT_DEF = 1;

    // Degenerate maps (e.g. a single output pixel) still need a 1-bit bus.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2_scheduler_tag_delay.sv
// Fixed-depth shift register carrying a valid flag and a data word, used to
// align write tags with the convolution datapath latency.
module tag_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    localparam int SW = W + 1;

    logic [DEPTH*SW-1:0] sr_q;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else begin
                sr_q <= {vld_i, data_i};
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else begin
                sr_q <= {sr_q[(DEPTH-1)*SW-1:0], vld_i, data_i};
            end
        end
    end

    assign {vld_o, data_o} = sr_q[DEPTH*SW-1 -: SW];

endmodule

// File: rtl/conv2_scheduler.sv
// Layer-2 convolution sequencer: streams the input map in raster order, tags
// fully in-bounds 3x3 windows and drives the output memory write port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | datapath held in reset, waiting for start
// ST_RUN   | one input read per cycle, addresses 0..IMG_W*IMG_H-1
// ST_DRAIN | reads finished, waiting for the last tagged write to emerge
module conv2_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int IN_AW    = safe_clog2(IMG_W * IMG_H),
    parameter int OUT_AW   = safe_clog2((IMG_W - 2) * (IMG_H - 2))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              in_rd,
    output logic [IN_AW-1:0]  in_addr,
    output logic              in_rdata_valid,
    output logic              dp_rst,
    output logic              out_wr,
    output logic [OUT_AW-1:0] out_addr
);

    localparam int RW    = safe_clog2(IMG_H);
    localparam int CW    = safe_clog2(IMG_W);
    localparam int TW    = OUT_AW + 1;
    localparam int DEPTH = 1 + PIPE_LAT;

    localparam logic [IN_AW-1:0] LAST_ADDR = IN_AW'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]    C_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    R_FIRST   = RW'(2);
    localparam logic [CW-1:0]    C_FIRST   = CW'(2);

    conv_state_e       state_q, state_d;
    logic              in_rd_q;
    logic              rdv_q;
    logic              busy_q;
    logic              dp_rst_q;
    logic [IN_AW-1:0]  in_addr_q, in_addr_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [OUT_AW-1:0] out_cnt_q, out_cnt_d;

    logic              running;
    logic              tag_vld;
    logic              tag_last;
    logic              pipe_vld;
    logic [TW-1:0]     pipe_data;

    assign running  = (state_q == ST_RUN);
    assign tag_vld  = running && (r_q >= R_FIRST) && (c_q >= C_FIRST);
    // The final raster pixel always closes a valid window, so "last" implies valid.
    assign tag_last = running && (in_addr_q == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)              state_d = ST_RUN;
            ST_RUN:   if (tag_last)           state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_data[TW-1])    state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_addr_d = '0;
        r_d       = '0;
        c_d       = '0;
        if (state_d == ST_RUN && running) begin
            in_addr_d = in_addr_q + 1'b1;
            if (c_q == C_LAST) begin
                r_d = r_q + 1'b1;
            end else begin
                r_d = r_q;
                c_d = c_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (state_q == ST_IDLE) begin
            out_cnt_d = '0;
        end else if (tag_vld) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            in_rd_q   <= 1'b0;
            rdv_q     <= 1'b0;
            busy_q    <= 1'b0;
            dp_rst_q  <= 1'b1;
            in_addr_q <= '0;
            r_q       <= '0;
            c_q       <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_rd_q   <= (state_d == ST_RUN);
            rdv_q     <= in_rd_q;
            busy_q    <= (state_d != ST_IDLE);
            dp_rst_q  <= (state_d == ST_IDLE);
            in_addr_q <= in_addr_d;
            r_q       <= r_d;
            c_q       <= c_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    tag_delay #(
        .DEPTH (DEPTH),
        .W     (TW)
    ) u_tag_delay (
        .clk    (clk),
        .rst_n  (rst),
        .vld_i  (tag_vld),
        .data_i ({tag_last, out_cnt_q}),
        .vld_o  (pipe_vld),
        .data_o (pipe_data)
    );

    assign busy           = busy_q;
    assign done           = pipe_data[TW-1];
    assign in_rd          = in_rd_q;
    assign in_addr        = in_addr_q;
    assign in_rdata_valid = rdv_q;
    assign dp_rst         = dp_rst_q;
    assign out_wr         = pipe_vld;
    assign out_addr       = pipe_data[OUT_AW-1:0];

endmodule

// File: tb/tb_conv2_scheduler.sv
// Self-checking bench for conv2_scheduler: four geometries checked cycle by
// cycle against a raster/window timing model derived from the frame rules.
module tb_conv2_scheduler;
    import conv_pkg::*;

    localparam int W0 = 5,         H0 = 4,         P0 = 1;
    localparam int W1 = IMG_W_DEF, H1 = IMG_H_DEF, P1 = PIPE_LAT_DEF;
    localparam int W2 = 5,         H2 = 4,         P2 = 3;
    localparam int W3 = 3,         H3 = 3,         P3 = 1;

    localparam int IA0 = safe_clog2(W0*H0), OA0 = safe_clog2((W0-2)*(H0-2));
    localparam int IA1 = safe_clog2(W1*H1), OA1 = safe_clog2((W1-2)*(H1-2));
    localparam int IA2 = safe_clog2(W2*H2), OA2 = safe_clog2((W2-2)*(H2-2));
    localparam int IA3 = safe_clog2(W3*H3), OA3 = safe_clog2((W3-2)*(H3-2));

    int cfg_w  [4] = '{W0, W1, W2, W3};
    int cfg_h  [4] = '{H0, H1, H2, H3};
    int cfg_pl [4] = '{P0, P1, P2, P3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] start_v;
    logic [3:0] busy_v, done_v, rd_v, rdv_v, dprst_v, wr_v;
    logic [IA0-1:0] ia0;  logic [OA0-1:0] oa0;
    logic [IA1-1:0] ia1;  logic [OA1-1:0] oa1;
    logic [IA2-1:0] ia2;  logic [OA2-1:0] oa2;
    logic [IA3-1:0] ia3;  logic [OA3-1:0] oa3;
    int unsigned ia_v [4];
    int unsigned oa_v [4];

    always_comb begin
        ia_v[0] = 32'(ia0); oa_v[0] = 32'(oa0);
        ia_v[1] = 32'(ia1); oa_v[1] = 32'(oa1);
        ia_v[2] = 32'(ia2); oa_v[2] = 32'(oa2);
        ia_v[3] = 32'(ia3); oa_v[3] = 32'(oa3);
    end

    conv2_scheduler #(.IMG_W(W0), .IMG_H(H0), .PIPE_LAT(P0)) d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .in_rd(rd_v[0]), .in_addr(ia0), .in_rdata_valid(rdv_v[0]), .dp_rst(dprst_v[0]),
        .out_wr(wr_v[0]), .out_addr(oa0));
    conv2_scheduler d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .in_rd(rd_v[1]), .in_addr(ia1), .in_rdata_valid(rdv_v[1]), .dp_rst(dprst_v[1]),
        .out_wr(wr_v[1]), .out_addr(oa1));
    conv2_scheduler #(.IMG_W(W2), .IMG_H(H2), .PIPE_LAT(P2)) d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .in_rd(rd_v[2]), .in_addr(ia2), .in_rdata_valid(rdv_v[2]), .dp_rst(dprst_v[2]),
        .out_wr(wr_v[2]), .out_addr(oa2));
    conv2_scheduler #(.IMG_W(W3), .IMG_H(H3), .PIPE_LAT(P3)) d3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .in_rd(rd_v[3]), .in_addr(ia3), .in_rdata_valid(rdv_v[3]), .dp_rst(dprst_v[3]),
        .out_wr(wr_v[3]), .out_addr(oa3));

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input logic [1:0] k, input string tag);
        chk({tag, ".busy"},   32'(busy_v[k]),  0);
        chk({tag, ".done"},   32'(done_v[k]),  0);
        chk({tag, ".in_rd"},  32'(rd_v[k]),    0);
        chk({tag, ".rdv"},    32'(rdv_v[k]),   0);
        chk({tag, ".dp_rst"}, 32'(dprst_v[k]), 1);
        chk({tag, ".out_wr"}, 32'(wr_v[k]),    0);
    endtask

    task automatic chk_reset_all(input string tag);
        for (int j = 0; j < 4; j++) begin
            chk_idle(2'(j), tag);
            chk({tag, ".in_addr"},  ia_v[j], 0);
            chk({tag, ".out_addr"}, oa_v[j], 0);
        end
    endtask

    // One frame on DUT k; start is randomly toggled mid-frame and must be ignored.
    task automatic run_frame(input logic [1:0] k, input bit hold);
        int w, h, pl, t, d, p, nwr, gap;
        bit exp_wr;
        w  = cfg_w[k];
        h  = cfg_h[k];
        pl = cfg_pl[k];
        t  = w * h;
        d  = t + 1 + pl;
        nwr = 0;
        gap = hold ? 0 : int'($urandom_range(0, 3));
        repeat (gap) begin
            @(negedge clk);
            chk_idle(k, "gap");
        end
        @(negedge clk);
        chk_idle(k, "pre");
        start_v[k] = 1'b1;
        for (int n = 1; n <= d; n++) begin
            @(negedge clk);
            if (!hold) start_v[k] = 1'($urandom_range(0, 1));
            p = n - 2 - pl;
            exp_wr = (p >= 0) && (p < t) && ((p / w) >= 2) && ((p % w) >= 2);
            chk("busy",   32'(busy_v[k]),  1);
            chk("dp_rst", 32'(dprst_v[k]), 0);
            chk("in_rd",  32'(rd_v[k]),    (n <= t) ? 1 : 0);
            if (n <= t) chk("in_addr", ia_v[k], 32'(n - 1));
            chk("rdv",    32'(rdv_v[k]),   (n >= 2 && n <= t + 1) ? 1 : 0);
            chk("done",   32'(done_v[k]),  (n == d) ? 1 : 0);
            chk("out_wr", 32'(wr_v[k]),    exp_wr ? 1 : 0);
            if (exp_wr)
                chk("out_addr", oa_v[k], 32'(((p / w) - 2) * (w - 2) + (p % w) - 2));
            if (wr_v[k] === 1'b1) begin
                chk("contig", oa_v[k], 32'(nwr));
                nwr++;
            end
        end
        chk("nwrites", 32'(nwr), 32'((w - 2) * (h - 2)));
        if (!hold) start_v[k] = 1'b0;
    endtask

    task automatic reset_mid(input logic [1:0] k, input int cyc);
        @(negedge clk);
        start_v[k] = 1'b1;
        for (int n = 1; n <= cyc; n++) begin
            @(negedge clk);
            start_v[k] = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk_reset_all("rst_async");
        repeat (2) begin
            @(negedge clk);
            chk_idle(k, "rst_hold");
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk_idle(k, "post_rst");
        end
    endtask

    initial begin
        rst     = 1'b0;
        start_v = '0;
        repeat (2) @(negedge clk);
        chk_reset_all("reset");
        rst = 1'b1;

        run_frame(2'd0, 1'b0);
        run_frame(2'd1, 1'b0);
        run_frame(2'd2, 1'b0);
        run_frame(2'd3, 1'b0);

        run_frame(2'd0, 1'b1);
        run_frame(2'd0, 1'b1);
        start_v[0] = 1'b0;

        reset_mid(2'd0, 10);
        run_frame(2'd0, 1'b0);
        reset_mid(2'd2, int'($urandom_range(13, 23)));
        run_frame(2'd2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame(2'(i == 1 ? 3 : $urandom_range(0, 3) & 2'b10 | i[0]), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
